// File: rtl/fft8_pkg.sv
// ---------------------------------------------------------------------------
// fft8_pkg
//   Shared definitions for the 8-point FFT frame controller.
//   - N_DEFAULT / W : default component exponent and width (W = 2**N bits)
//   - PTS           : points per frame
//   - in_state_t    : input sequencer states (COLLECT / FULL)
//   - out_state_t   : output serializer states (IDLE / DRAIN)
//   - fsm_dbg_t     : both FSM states bundled for observation
//   - bitrev3       : 3-bit index reversal used to place samples in the frame
// ---------------------------------------------------------------------------
package fft8_pkg;

    localparam int N_DEFAULT = 3;
    localparam int W         = 2 ** N_DEFAULT;
    localparam int PTS       = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } in_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } out_state_t;

    typedef struct packed {
        in_state_t  in_st;
        out_state_t out_st;
    } fsm_dbg_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft8_out_serializer.sv
// ---------------------------------------------------------------------------
// fft8_out_serializer
//   Captures the 8 parallel core results in one cycle and replays them in
//   natural order (bin 0 first) on a valid/ready stream.
//
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     capture          : one-cycle strobe, cap_r/cap_i hold valid results
//     cap_r, cap_i     : 8 results, slot j = bits [j*DW +: DW]
//     m_ready          : sink accepts the presented bin
//     m_valid          : a bin is presented
//     m_r, m_i         : presented bin
//     m_last           : presented bin is bin 7
//     out_full         : buffer holds a frame that has not fully drained
//     state            : current serializer state
//
//   All m_* outputs are registered; while m_ready is low they do not change.
// ---------------------------------------------------------------------------
module fft8_out_serializer
    import fft8_pkg::*;
#(
    parameter int DW = W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [PTS*DW-1:0] cap_r,
    input  logic [PTS*DW-1:0] cap_i,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DW-1:0]     m_r,
    output logic [DW-1:0]     m_i,
    output logic              m_last,
    output logic              out_full,
    output out_state_t        state
);

    logic [PTS*DW-1:0] obuf_r;
    logic [PTS*DW-1:0] obuf_i;
    logic [2:0]        out_cnt;
    logic [2:0]        nxt_cnt;

    assign nxt_cnt  = out_cnt + 3'd1;
    // The buffer is occupied exactly while draining.
    assign out_full = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_cnt <= 3'd0;
            obuf_r  <= '0;
            obuf_i  <= '0;
            m_valid <= 1'b0;
            m_r     <= '0;
            m_i     <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        obuf_r  <= cap_r;
                        obuf_i  <= cap_i;
                        out_cnt <= 3'd0;
                        m_valid <= 1'b1;
                        m_r     <= cap_r[DW-1:0];
                        m_i     <= cap_i[DW-1:0];
                        m_last  <= 1'b0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // m_valid is high throughout DRAIN, so m_ready alone is the handshake.
                    if (m_ready) begin
                        if (out_cnt == 3'd7) begin
                            out_cnt <= 3'd0;
                            m_valid <= 1'b0;
                            m_r     <= '0;
                            m_i     <= '0;
                            m_last  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            out_cnt <= nxt_cnt;
                            m_r     <= obuf_r[int'(nxt_cnt)*DW +: DW];
                            m_i     <= obuf_i[int'(nxt_cnt)*DW +: DW];
                            m_last  <= (nxt_cnt == 3'd7);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft8_frame_ctrl
//   Front/back-end sequencer for the 8-point parallel FFT core. Collects 8
//   streamed samples into a bit-reversed frame, launches it into the core with
//   a one-cycle strobe, follows the core latency with a token shift register
//   and hands the results to the output serializer.
//
//   Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid && ready are both high; the source keeps data and valid
//   stable until that edge, and ready never depends combinationally on valid.
//
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     s_valid/s_ready          : input sample handshake
//     s_r, s_i, s_last         : input sample and end-of-frame marker
//     core_start               : one-cycle launch strobe
//     core_in_r, core_in_i     : frame to the core, slot j already bit-reversed
//     core_out_r, core_out_i   : core results, slot j = X[j]
//     m_valid/m_ready          : output bin handshake
//     m_r, m_i, m_last         : output bin, m_last with bin 7
//     frame_err                : one-cycle pulse on a framing error
//     busy                     : a frame is in the core or the output buffer
//     dbg_state                : current state of both FSMs
// ---------------------------------------------------------------------------
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int CORE_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [2**N-1:0]       s_r,
    input  logic [2**N-1:0]       s_i,
    input  logic                  s_last,
    output logic                  core_start,
    output logic [PTS*2**N-1:0]   core_in_r,
    output logic [PTS*2**N-1:0]   core_in_i,
    input  logic [PTS*2**N-1:0]   core_out_r,
    input  logic [PTS*2**N-1:0]   core_out_i,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2**N-1:0]       m_r,
    output logic [2**N-1:0]       m_i,
    output logic                  m_last,
    output logic                  frame_err,
    output logic                  busy,
    output fsm_dbg_t              dbg_state
);

    localparam int DW = 2 ** N;

    in_state_t         in_st;
    out_state_t        out_st;
    logic [2:0]        in_cnt;
    logic [PTS*DW-1:0] frame_r;
    logic [PTS*DW-1:0] frame_i;
    logic [CORE_LAT-1:0] tok;
    logic              out_full;
    logic              capture;
    logic              launch;
    logic              s_hs;

    assign s_hs    = s_valid && s_ready;
    // The token leaving the last stage marks valid core outputs this cycle.
    assign capture = tok[CORE_LAT-1];
    // out_full is the registered flag, so a launch never overlaps the final
    // output handshake; it follows one cycle later.
    assign launch  = (in_st == FULL) && !(|tok) && !out_full;
    assign busy    = (|tok) || out_full;

    assign dbg_state.in_st  = in_st;
    assign dbg_state.out_st = out_st;

    // Input sequencer: COLLECT fills the working frame, FULL waits for launch.
    // The working frame is separate from core_in_* so the next frame can be
    // collected while the previous one is still in the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_st      <= COLLECT;
            in_cnt     <= 3'd0;
            s_ready    <= 1'b1;
            frame_r    <= '0;
            frame_i    <= '0;
            core_in_r  <= '0;
            core_in_i  <= '0;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            case (in_st)
                COLLECT: begin
                    if (s_hs) begin
                        frame_r[int'(bitrev3(in_cnt))*DW +: DW] <= s_r;
                        frame_i[int'(bitrev3(in_cnt))*DW +: DW] <= s_i;
                        if (in_cnt == 3'd7) begin
                            // Eighth sample closes the frame even without s_last.
                            in_cnt    <= 3'd0;
                            s_ready   <= 1'b0;
                            frame_err <= !s_last;
                            in_st     <= FULL;
                        end else if (s_last) begin
                            // Early end marker: drop the partial frame.
                            in_cnt    <= 3'd0;
                            frame_err <= 1'b1;
                        end else begin
                            in_cnt <= in_cnt + 3'd1;
                        end
                    end
                end
                FULL: begin
                    if (launch) begin
                        core_start <= 1'b1;
                        core_in_r  <= frame_r;
                        core_in_i  <= frame_i;
                        s_ready    <= 1'b1;
                        in_st      <= COLLECT;
                    end
                end
                default: in_st <= COLLECT;
            endcase
        end
    end

    // Latency tracker: one token per launch, shifted once per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok <= '0;
        end else begin
            tok[0] <= core_start;
            for (int k = 1; k < CORE_LAT; k++) begin
                tok[k] <= tok[k-1];
            end
        end
    end

    fft8_out_serializer #(
        .DW (DW)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .cap_r    (core_out_r),
        .cap_i    (core_out_i),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_r      (m_r),
        .m_i      (m_i),
        .m_last   (m_last),
        .out_full (out_full),
        .state    (out_st)
    );

endmodule
